// File: rtl/apb_controller_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_controller_fsm_if
// Brief    : AHB-request / APB-bus bundle for the bridge transfer sequencer.
//            Pready exists only when APB_PREADY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_controller_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
);
    logic                  Valid;
    logic                  Hwrite;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic [NUM_SLAVES-1:0] Tempselx;
    logic [DATA_WIDTH-1:0] Prdata;
`ifdef APB_PREADY_EN
    logic                  Pready;
`endif
    logic                  Pwrite;
    logic                  Penable;
    logic [NUM_SLAVES-1:0] Pselx;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic                  Hreadyout;
    logic [DATA_WIDTH-1:0] Hrdata;

    // Bridge side
    modport slave (
`ifdef APB_PREADY_EN
        input  Pready,
`endif
        input  Valid, Hwrite, Haddr, Hwdata, Tempselx, Prdata,
        output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
    );

    // Upstream decoder / APB slave side
    modport master (
`ifdef APB_PREADY_EN
        output Pready,
`endif
        output Valid, Hwrite, Haddr, Hwdata, Tempselx, Prdata,
        input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : apb_controller_fsm
// Brief    : AHB-to-APB transfer sequencer (SETUP/ACCESS generation).
//            Optional macro APB_PREADY_EN adds Pready wait-state support.
// Revision : 1.0 - initial release
// ============================================================================
module apb_controller_fsm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic           Hclk,
    input  logic           Hreset,
    apb_controller_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WWAIT   = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        RENABLE = 3'd4,
        WENABLE = 3'd5
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  pready;
    logic                  ready_out;
    logic                  accept;
    logic                  apb_active;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [NUM_SLAVES-1:0] held_sel;
    logic                  held_write;
    logic [ADDR_WIDTH-1:0] apb_addr;
    logic                  apb_write;
    logic [DATA_WIDTH-1:0] apb_wdata;

`ifdef APB_PREADY_EN
    assign pready = bus.Pready;
`else
    assign pready = 1'b1;
`endif

    always_comb begin
        ready_out = 1'b0;
        case (state)
            IDLE:             ready_out = 1'b1;
            RENABLE, WENABLE: ready_out = pready;
            default:          ready_out = 1'b0;
        endcase
    end

    assign accept = ready_out & bus.Valid & (|bus.Tempselx);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = bus.Hwrite ? WWAIT : READ;
            end
            WWAIT:   next_state = WRITE;
            READ:    next_state = RENABLE;
            WRITE:   next_state = WENABLE;
            RENABLE, WENABLE: begin
                if (pready) begin
                    if (accept) next_state = bus.Hwrite ? WWAIT : READ;
                    else        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // APB address/direction/data are registered on entry to SETUP so they
    // keep their previous values through IDLE and WWAIT.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state      <= IDLE;
            held_addr  <= '0;
            held_sel   <= '0;
            held_write <= 1'b0;
            apb_addr   <= '0;
            apb_write  <= 1'b0;
            apb_wdata  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                held_addr  <= bus.Haddr;
                held_sel   <= bus.Tempselx;
                held_write <= bus.Hwrite;
            end
            if (next_state == READ) begin
                apb_addr  <= bus.Haddr;
                apb_write <= 1'b0;
            end
            if (state == WWAIT) begin
                apb_addr  <= held_addr;
                apb_write <= held_write;
                apb_wdata <= bus.Hwdata;
            end
        end
    end

    assign apb_active    = (state == READ) || (state == WRITE) ||
                           (state == RENABLE) || (state == WENABLE);
    assign bus.Pselx     = apb_active ? held_sel : '0;
    assign bus.Penable   = (state == RENABLE) || (state == WENABLE);
    assign bus.Paddr     = apb_addr;
    assign bus.Pwrite    = apb_write;
    assign bus.Pwdata    = apb_wdata;
    assign bus.Hreadyout = ready_out;
    assign bus.Hrdata    = ((state == RENABLE) && pready) ? bus.Prdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_controller_fsm
// Brief    : Self-checking bench; expected bus activity derived from a
//            transaction list and the read/write latency rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_controller_fsm;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NS   = 3;
    localparam int MAXC = 512;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            gap;
    } txn_t;

    logic Hclk = 1'b0;
    logic Hreset;
    int   checks   = 0;
    int   failures = 0;

    // Last values the APB address/direction/data lines should hold.
    logic [AW-1:0] m_paddr  = '0;
    logic          m_pwrite = 1'b0;
    logic [DW-1:0] m_pwdata = '0;

    txn_t txq[$];
    int   ph_a[MAXC];   // 0 idle, 1 write-data wait, 2 setup, 3 access
    int   ti_a[MAXC];
    int   rq_a[MAXC];

    always #5 Hclk = ~Hclk;

    apb_controller_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    apb_controller_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    function automatic logic [NS-1:0] rand_sel();
        logic [NS-1:0] one;
        one = 1;
        return one << $urandom_range(0, NS - 1);
    endfunction

    // Runs txq cycle by cycle, starting just after an edge with the DUT idle.
    task automatic run_schedule(input string name, input int tail);
        int   c, r, total, ph;
        bit   hr_exp;
        txn_t t;
        logic [NS-1:0] e_psel;
        logic          e_pen;
        logic [DW-1:0] e_hrd;
        for (int i = 0; i < MAXC; i++) begin
            ph_a[i] = 0; ti_a[i] = -1; rq_a[i] = -1;
        end
        c = 0;
        foreach (txq[i]) begin
            r = c;
            rq_a[r] = i;
            if (txq[i].wr) begin
                ph_a[r+1] = 1; ph_a[r+2] = 2; ph_a[r+3] = 3;
                ti_a[r+1] = i; ti_a[r+2] = i; ti_a[r+3] = i;
                c = r + 3 + txq[i].gap;
            end else begin
                ph_a[r+1] = 2; ph_a[r+2] = 3;
                ti_a[r+1] = i; ti_a[r+2] = i;
                c = r + 2 + txq[i].gap;
            end
        end
        total = c + tail;
        for (int cy = 0; cy < total; cy++) begin
            ph     = ph_a[cy];
            hr_exp = (ph == 0) || (ph == 3);
            bus.Valid    = 1'($urandom_range(0, 1));
            bus.Hwrite   = 1'($urandom_range(0, 1));
            bus.Haddr    = $urandom;
            bus.Hwdata   = $urandom;
            bus.Prdata   = $urandom;
            bus.Tempselx = hr_exp ? '0 : rand_sel();
            if (rq_a[cy] >= 0) begin
                t = txq[rq_a[cy]];
                bus.Valid    = 1'b1;
                bus.Hwrite   = t.wr;
                bus.Haddr    = t.addr;
                bus.Tempselx = t.sel;
            end
            e_psel = '0; e_pen = 1'b0; e_hrd = '0;
            if (ti_a[cy] >= 0) begin
                t = txq[ti_a[cy]];
                if (ph == 1) bus.Hwdata = t.wdata;
                if (ph == 3 && !t.wr) bus.Prdata = t.rdata;
                if (ph == 2) begin
                    m_paddr  = t.addr;
                    m_pwrite = t.wr;
                    if (t.wr) m_pwdata = t.wdata;
                end
                if (ph >= 2) e_psel = t.sel;
                if (ph == 3) begin
                    e_pen = 1'b1;
                    if (!t.wr) e_hrd = t.rdata;
                end
            end
            #1;
            checks++; if (bus.Pselx !== e_psel) begin failures++;
                $display("FAIL %s cyc%0d Pselx got=%0h exp=%0h", name, cy, bus.Pselx, e_psel); end
            checks++; if (bus.Penable !== e_pen) begin failures++;
                $display("FAIL %s cyc%0d Penable got=%0b exp=%0b", name, cy, bus.Penable, e_pen); end
            checks++; if (bus.Hreadyout !== hr_exp) begin failures++;
                $display("FAIL %s cyc%0d Hreadyout got=%0b exp=%0b", name, cy, bus.Hreadyout, hr_exp); end
            checks++; if (bus.Hrdata !== e_hrd) begin failures++;
                $display("FAIL %s cyc%0d Hrdata got=%0h exp=%0h", name, cy, bus.Hrdata, e_hrd); end
            checks++; if (bus.Paddr !== m_paddr) begin failures++;
                $display("FAIL %s cyc%0d Paddr got=%0h exp=%0h", name, cy, bus.Paddr, m_paddr); end
            checks++; if (bus.Pwrite !== m_pwrite) begin failures++;
                $display("FAIL %s cyc%0d Pwrite got=%0b exp=%0b", name, cy, bus.Pwrite, m_pwrite); end
            checks++; if (bus.Pwdata !== m_pwdata) begin failures++;
                $display("FAIL %s cyc%0d Pwdata got=%0h exp=%0h", name, cy, bus.Pwdata, m_pwdata); end
            @(posedge Hclk); #1;
        end
        txq.delete();
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h1234_5678;
        bus.Tempselx = 3'b001; bus.Hwdata = '0; bus.Prdata = 32'hFFFF_FFFF;
`ifdef APB_PREADY_EN
        bus.Pready = 1'b1;
`endif
        repeat (2) @(posedge Hclk);
        #1;
        checks++; if (bus.Pselx !== '0 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b1) begin
            failures++;
            $display("FAIL reset ctrl got psel=%0h pen=%0b rdy=%0b exp psel=0 pen=0 rdy=1",
                     bus.Pselx, bus.Penable, bus.Hreadyout);
        end
        checks++; if (bus.Paddr !== '0 || bus.Pwdata !== '0 || bus.Pwrite !== 1'b0 || bus.Hrdata !== '0) begin
            failures++;
            $display("FAIL reset data got paddr=%0h pwdata=%0h pwrite=%0b hrdata=%0h exp all 0",
                     bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Hrdata);
        end
        Hreset = 1'b0;
        bus.Valid = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
        run_schedule("idle_after_reset", 5);
    endtask

    task automatic test_single_read();
        txq.push_back('{wr: 1'b0, addr: 32'h8000_0010, sel: 3'b001, wdata: '0,
                        rdata: 32'hA5A5_0010, gap: 1});
        run_schedule("single_read", 1);
    endtask

    task automatic test_single_write();
        txq.push_back('{wr: 1'b1, addr: 32'h8400_0004, sel: 3'b010, wdata: 32'hDEAD_BEEF,
                        rdata: '0, gap: 1});
        run_schedule("single_write", 1);
    endtask

    task automatic test_back_to_back();
        txq.push_back('{wr: 1'b0, addr: 32'h8800_0020, sel: 3'b100, wdata: '0,
                        rdata: 32'h0BAD_F00D, gap: 0});
        txq.push_back('{wr: 1'b1, addr: 32'h8000_0030, sel: 3'b001, wdata: 32'hCAFE_0001,
                        rdata: '0, gap: 1});
        run_schedule("back_to_back", 1);
    endtask

    // Only idle cycles: Valid toggles randomly with Tempselx=0 and must be ignored.
    task automatic test_invalid_select();
        run_schedule("invalid_select", 6);
    endtask

    task automatic test_reset_mid_write();
        bus.Valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8400_0100; bus.Tempselx = 3'b100;
        @(posedge Hclk); #1;
        bus.Valid = 1'b0; bus.Tempselx = '0; bus.Hwdata = 32'h1357_9BDF;
        #1;
        checks++; if (bus.Hreadyout !== 1'b0 || bus.Pselx !== '0) begin failures++;
            $display("FAIL rst_mid wwait got rdy=%0b psel=%0h exp rdy=0 psel=0", bus.Hreadyout, bus.Pselx); end
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Tempselx = 3'b001; bus.Prdata = 32'h5555_AAAA;
        #1;
        checks++; if (bus.Pselx !== 3'b100 || bus.Pwrite !== 1'b1 || bus.Pwdata !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL rst_mid setup got psel=%0h pwrite=%0b pwdata=%0h exp psel=4 pwrite=1 pwdata=13579bdf",
                     bus.Pselx, bus.Pwrite, bus.Pwdata);
        end
        @(posedge Hclk); #1;
        checks++; if (bus.Pselx !== '0 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b1) begin failures++;
            $display("FAIL rst_mid ctrl got psel=%0h pen=%0b rdy=%0b exp psel=0 pen=0 rdy=1",
                     bus.Pselx, bus.Penable, bus.Hreadyout); end
        checks++; if (bus.Paddr !== '0 || bus.Pwdata !== '0 || bus.Pwrite !== 1'b0 || bus.Hrdata !== '0) begin
            failures++;
            $display("FAIL rst_mid data got paddr=%0h pwdata=%0h pwrite=%0b hrdata=%0h exp all 0",
                     bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Hrdata);
        end
        Hreset = 1'b0;
        bus.Valid = 1'b0; bus.Tempselx = '0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
        run_schedule("after_rst_mid", 2);
    endtask

    task automatic test_random();
        txn_t t;
        for (int i = 0; i < 40; i++) begin
            t.wr    = 1'($urandom_range(0, 1));
            t.addr  = $urandom;
            t.sel   = rand_sel();
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.gap   = $urandom_range(0, 2);
            txq.push_back(t);
        end
        run_schedule("random", 2);
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready_stall();
        bus.Valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8000_0444; bus.Tempselx = 3'b010;
        @(posedge Hclk); #1;
        bus.Valid = 1'b0; bus.Tempselx = '0; bus.Hwdata = 32'h2468_ACE0;
        @(posedge Hclk); #1;
        @(posedge Hclk); #1;
        for (int k = 0; k < 4; k++) begin
            bus.Pready = (k == 3);
            bus.Prdata = $urandom;
            #1;
            checks++; if (bus.Penable !== 1'b1 || bus.Pselx !== 3'b010 || bus.Paddr !== 32'h8000_0444 ||
                          bus.Pwdata !== 32'h2468_ACE0 || bus.Pwrite !== 1'b1) begin
                failures++;
                $display("FAIL pready k%0d apb got pen=%0b psel=%0h paddr=%0h pwdata=%0h pwrite=%0b exp 1/2/80000444/2468ace0/1",
                         k, bus.Penable, bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite);
            end
            checks++; if (bus.Hreadyout !== (k == 3) || bus.Hrdata !== '0) begin failures++;
                $display("FAIL pready k%0d got rdy=%0b hrdata=%0h exp rdy=%0b hrdata=0",
                         k, bus.Hreadyout, bus.Hrdata, (k == 3)); end
            @(posedge Hclk); #1;
        end
        #1;
        checks++; if (bus.Penable !== 1'b0 || bus.Pselx !== '0 || bus.Hreadyout !== 1'b1) begin failures++;
            $display("FAIL pready_end got pen=%0b psel=%0h rdy=%0b exp pen=0 psel=0 rdy=1",
                     bus.Penable, bus.Pselx, bus.Hreadyout); end
        m_paddr = 32'h8000_0444; m_pwrite = 1'b1; m_pwdata = 32'h2468_ACE0;
        run_schedule("after_pready", 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_invalid_select();
        test_reset_mid_write();
        test_random();
`ifdef APB_PREADY_EN
        test_pready_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
